// File: rtl/ucounter_gen.sv
// ucounter_gen: configurable up/down counter with optional prescaler.
//
// Ports:
//   clk        - single clock, all state updates on rising edge
//   _areset    - synchronous active-high reset (highest priority)
//   en         - count enable; prescaler and counter advance while high
//   _aset      - synchronous set of dcount to all-ones
//   _load      - synchronous load of dcount from preld_val
//   preld_val  - preload value
//   _updown    - direction, 1 = up, 0 = down (sampled on tick cycles)
//   _wrapstop  - limit mode, 1 = wrap, 0 = stop at limit (sampled on ticks)
//   prescale   - tick divisor minus one; 0 = tick every enabled cycle
//   cmp_val    - compare value
//   dcount     - registered count
//   overflow   - one-cycle registered pulse on an up-limit event
//   underflow  - one-cycle registered pulse on a down-limit event
//   done       - registered; high while halted at a limit in stop mode
//   cmp_match  - combinational (dcount == cmp_val)
//
// Configuration macro: UCOUNTER_PRESCALE_EN
//   defined   - prescaler register divides en into ticks
//   undefined - no prescaler; tick = en & ~done every cycle
module ucounter_gen #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  _areset,
  input  logic                  en,
  input  logic                  _aset,
  input  logic                  _load,
  input  logic [WIDTH-1:0]      preld_val,
  input  logic                  _updown,
  input  logic                  _wrapstop,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cmp_val,
  output logic [WIDTH-1:0]      dcount,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  done,
  output logic                  cmp_match
);

  logic [WIDTH-1:0] dcount_q, dcount_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef UCOUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_q, psc_d;

  // >= rather than == so a divisor lowered mid-period still ticks
  // instead of running the prescaler round its full range.
  assign tick = en && !done_q && (psc_q >= prescale);
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign tick = en && !done_q;
`endif

  always_comb begin
    dcount_d    = dcount_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    done_d      = done_q;
`ifdef UCOUNTER_PRESCALE_EN
    psc_d       = psc_q;
`endif
    if (_aset) begin
      dcount_d = '1;
      done_d   = 1'b0;
`ifdef UCOUNTER_PRESCALE_EN
      psc_d    = '0;
`endif
    end else if (_load) begin
      dcount_d = preld_val;
      done_d   = 1'b0;
`ifdef UCOUNTER_PRESCALE_EN
      psc_d    = '0;
`endif
    end else begin
`ifdef UCOUNTER_PRESCALE_EN
      if (en && !done_q) begin
        psc_d = tick ? '0 : psc_q + PRESCALE_W'(1);
      end
`endif
      if (tick) begin
        if (_updown) begin
          if (dcount_q == '1) begin
            overflow_d = 1'b1;
            if (_wrapstop) dcount_d = '0;
            else           done_d   = 1'b1;
          end else begin
            dcount_d = dcount_q + WIDTH'(1);
          end
        end else begin
          if (dcount_q == '0) begin
            underflow_d = 1'b1;
            if (_wrapstop) dcount_d = '1;
            else           done_d   = 1'b1;
          end else begin
            dcount_d = dcount_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (_areset) begin
      dcount_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef UCOUNTER_PRESCALE_EN
      psc_q       <= '0;
`endif
    end else begin
      dcount_q    <= dcount_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      done_q      <= done_d;
`ifdef UCOUNTER_PRESCALE_EN
      psc_q       <= psc_d;
`endif
    end
  end

  assign dcount    = dcount_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign done      = done_q;
  assign cmp_match = (dcount_q == cmp_val);

endmodule
